aco_ctrl: RTL and testbench
===========================

// Module: aco_ctrl
// PURPOSE
//  Run-time sequencer for the aco featurisation pipeline. Owns aco's en_i, shift_i and wr_en, gates mic
//  samples into it, and frames aco's 50-vector output windows for the word detector. Handles start/stop
//  at window granularity, warm-up window discard, window-alignment checks and a stall watchdog.
// PARAMETERS
//  SHIFT_BW     8      quant shift width (matches aco shift_i)
//  I_BW         8      mic sample width
//  WIN_LEN      50     feature vectors per aco output window
//  DISCARD_WIN  1      windows dropped after start (pipeline fill)
//  CNT_BW       16     width of window counter / num_win_i
//  WDOG_BW      20     watchdog counter width
// PORTS
//  clk_i        in   1         clock
//  rst_i        in   1         async reset, active-high
//  cfg_shift_i  in   SHIFT_BW  quant shift value
//  cfg_wr_i     in   1         1-cycle pulse: program cfg_shift_i into aco
//  start_i      in   1         1-cycle pulse: begin capture
//  stop_i       in   1         1-cycle pulse: stop at next window boundary
//  num_win_i    in   CNT_BW    windows to deliver per run; 0 = unbounded; sampled on start_i
//  wdog_lim_i   in   WDOG_BW   max idle cycles between aco_valid_i; 0 = watchdog off
//  mic_data_i   in   I_BW      signed mic sample
//  mic_valid_i  in   1         mic sample strobe
//  aco_en_o     out  1         to aco en_i
//  aco_shift_o  out  SHIFT_BW  to aco shift_i
//  aco_wr_en_o  out  1         to aco wr_en
//  aco_data_o   out  I_BW      to aco data_i (registered copy of mic_data_i)
//  aco_valid_o  out  1         to aco valid_i
//  aco_valid_i  in   1         from aco valid_o
//  aco_last_i   in   1         from aco last_o
//  out_valid_o  out  1         aco_valid_i qualified (delivered windows only)
//  out_last_o   out  1         aco_last_i qualified
//  win_cnt_o    out  CNT_BW    windows delivered this run
//  busy_o       out  1         state != IDLE
//  done_o       out  1         1-cycle pulse on return to IDLE from a run
//  err_o        out  3         sticky {wdog, align, cfg}; cleared on accepted start_i
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; aco_shift_o=0; counters 0.
//  States: IDLE, CFG, WARM, RUN, STOP.
//   IDLE: aco_en_o=0, aco_valid_o=0. cfg_wr_i -> latch shift, CFG. start_i -> latch num_win_i, clear err_o/
//    win_cnt_o, WARM (RUN if DISCARD_WIN=0). Same-cycle cfg_wr_i and start_i: cfg wins, start dropped.
//   CFG: exactly 1 cycle; aco_en_o=1, aco_wr_en_o=1, aco_shift_o holds new value -> IDLE.
//   WARM: aco_en_o=1; samples pass; out_* forced 0. Counts aco_last_i; after DISCARD_WIN -> RUN.
//   RUN: out_valid_o=aco_valid_i, out_last_o=aco_last_i (combinational). aco_last_i -> win_cnt_o+1;
//    if win_cnt_o+1==num_win_i (num_win_i!=0) -> IDLE, done_o. stop_i -> STOP.
//   STOP: as RUN, but next aco_last_i -> IDLE, done_o. Window in flight completes intact.
//  Sample path: aco_data_o/aco_valid_o registered, 1-cycle latency; aco_valid_o=mic_valid_i & (WARM|RUN|STOP).
//  aco_shift_o changes only in CFG; aco_wr_en_o high only in CFG.
//  cfg_wr_i outside IDLE: ignored, err_o[0] set. start_i outside IDLE: ignored. stop_i in IDLE/CFG/WARM:
//   WARM -> IDLE immediately (no done_o); else ignored.
//  Alignment: vector counter counts aco_valid_i in WARM/RUN/STOP, wraps at WIN_LEN. aco_last_i with
//   count!=WIN_LEN-1, or count reaching WIN_LEN-1 without last: err_o[1] set, counter resyncs to 0 on last.
//  Watchdog: in WARM/RUN/STOP counts cycles, cleared by aco_valid_i; on reaching wdog_lim_i (nonzero):
//   err_o[2] set, -> IDLE, no done_o.
//  win_cnt_o saturates at all-ones; holds after run ends until next start.
//  Reset mid-run: everything to reset values at once; aco_en_o drops asynchronously.
// STRUCTURE
//  aco_ctrl_defs.vh: state encodings, err_o bit indices, default WIN_LEN/DISCARD_WIN.
//  One sub-module: aco_wdog (load/clear/enable counter, WDOG_BW, expire flag). FSM + counters inline.
// TESTING
//  cfg_wr_i shift=5 in IDLE -> aco_wr_en_o 1 cycle, aco_en_o 1 cycle, aco_shift_o=5 held; busy_o 1 cycle.
//  start_i num_win=2, DISCARD_WIN=1, model aco emits 3 windows of 50 -> out_valid_o only on windows 2-3,
//   win_cnt_o=2, done_o pulse after 3rd last, aco_en_o=0 next cycle.
//  num_win=0, stop_i at vector 20 of a window -> window completes (30 more out_valid_o), done_o, IDLE.
//  aco_last_i at vector 40 -> err_o=3'b010, next window counted normally; cfg_wr_i in RUN -> err_o[0]=1.
//  wdog_lim_i=100, aco stalls 100 cycles in RUN -> err_o[2]=1, IDLE, no done_o; start_i clears err_o.
//  rst_i asserted mid-RUN -> all outputs 0 same cycle; fresh start_i behaves as first run.

Source files
------------

// File: rtl/aco_ctrl_pkg.sv
// rtl/aco_ctrl_pkg.sv - shared constants for the aco run-time sequencer
package aco_ctrl_pkg;

  localparam int DEF_SHIFT_BW    = 8;
  localparam int DEF_I_BW        = 8;
  localparam int DEF_CNT_BW      = 16;
  localparam int DEF_WDOG_BW     = 20;
  localparam int DEF_WIN_LEN     = 50;
  localparam int DEF_DISCARD_WIN = 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CFG  = 3'd1;
  localparam logic [2:0] ST_WARM = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_STOP = 3'd4;

  localparam int ERR_CFG   = 0;
  localparam int ERR_ALIGN = 1;
  localparam int ERR_WDOG  = 2;

  // States in which aco is fed and its output is being tracked
  function automatic logic is_active(input logic [2:0] st);
    return (st == ST_WARM) || (st == ST_RUN) || (st == ST_STOP);
  endfunction

endpackage

// File: rtl/aco_ctrl_if.sv
// rtl/aco_ctrl_if.sv - host, mic and aco signal bundle of the aco sequencer
interface aco_ctrl_if
  import aco_ctrl_pkg::*;
#(
  parameter int SHIFT_BW = DEF_SHIFT_BW,
  parameter int I_BW     = DEF_I_BW,
  parameter int CNT_BW   = DEF_CNT_BW,
  parameter int WDOG_BW  = DEF_WDOG_BW
);
  logic [SHIFT_BW-1:0] cfg_shift_i;
  logic                cfg_wr_i;
  logic                start_i;
  logic                stop_i;
  logic [CNT_BW-1:0]   num_win_i;
  logic [WDOG_BW-1:0]  wdog_lim_i;
  logic [I_BW-1:0]     mic_data_i;
  logic                mic_valid_i;
  logic                aco_en_o;
  logic [SHIFT_BW-1:0] aco_shift_o;
  logic                aco_wr_en_o;
  logic [I_BW-1:0]     aco_data_o;
  logic                aco_valid_o;
  logic                aco_valid_i;
  logic                aco_last_i;
  logic                out_valid_o;
  logic                out_last_o;
  logic [CNT_BW-1:0]   win_cnt_o;
  logic                busy_o;
  logic                done_o;
  logic [2:0]          err_o;

  modport master (
    output cfg_shift_i, cfg_wr_i, start_i, stop_i, num_win_i, wdog_lim_i,
           mic_data_i, mic_valid_i, aco_valid_i, aco_last_i,
    input  aco_en_o, aco_shift_o, aco_wr_en_o, aco_data_o, aco_valid_o,
           out_valid_o, out_last_o, win_cnt_o, busy_o, done_o, err_o
  );

  modport slave (
    input  cfg_shift_i, cfg_wr_i, start_i, stop_i, num_win_i, wdog_lim_i,
           mic_data_i, mic_valid_i, aco_valid_i, aco_last_i,
    output aco_en_o, aco_shift_o, aco_wr_en_o, aco_data_o, aco_valid_o,
           out_valid_o, out_last_o, win_cnt_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/aco_wdog.sv
// rtl/aco_wdog.sv - idle-cycle watchdog between aco output vectors
module aco_wdog #(
  parameter int WDOG_BW = 20
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [WDOG_BW-1:0] lim_i,
  output logic               expired_o
);

  logic [WDOG_BW-1:0] cnt_q, cnt_d;
  logic [WDOG_BW:0]   cnt_nxt;

  assign cnt_nxt = {1'b0, cnt_q} + (WDOG_BW+1)'(1);
  // Fires on the idle cycle that brings the count up to the limit
  assign expired_o = en_i & ~clr_i & (|lim_i) & (cnt_nxt >= {1'b0, lim_i});

  // Count idle cycles while enabled; a vector or disable restarts the count
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || clr_i) begin
      cnt_d = '0;
    end else if (!(&cnt_q)) begin
      cnt_d = cnt_q + WDOG_BW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/aco_ctrl.sv
// rtl/aco_ctrl.sv - run-time sequencer and window framer for the aco pipeline
module aco_ctrl
  import aco_ctrl_pkg::*;
#(
  parameter int SHIFT_BW    = DEF_SHIFT_BW,
  parameter int I_BW        = DEF_I_BW,
  parameter int CNT_BW      = DEF_CNT_BW,
  parameter int WDOG_BW     = DEF_WDOG_BW,
  parameter int WIN_LEN     = DEF_WIN_LEN,
  parameter int DISCARD_WIN = DEF_DISCARD_WIN
) (
  input logic       clk_i,
  input logic       rst_i,
  aco_ctrl_if.slave bus
);

  localparam int VEC_BW = $clog2(WIN_LEN);
  localparam logic [VEC_BW-1:0] VEC_LAST = VEC_BW'(WIN_LEN - 1);

  logic [2:0]          state_q, state_d;
  logic [SHIFT_BW-1:0] shift_q, shift_d;
  logic [CNT_BW-1:0]   num_q, num_d;
  logic [CNT_BW-1:0]   win_q, win_d, win_inc;
  logic [CNT_BW-1:0]   warm_q, warm_d, warm_inc;
  logic [VEC_BW-1:0]   vec_q, vec_d;
  logic [2:0]          err_q, err_d;
  logic                done_q, done_d;
  logic [I_BW-1:0]     data_q, data_d;
  logic                valid_q, valid_d;
  logic                active, deliver, wdog_exp;

  assign active   = is_active(state_q);
  assign deliver  = (state_q == ST_RUN) || (state_q == ST_STOP);
  assign win_inc  = (&win_q) ? win_q : win_q + CNT_BW'(1);
  assign warm_inc = warm_q + CNT_BW'(1);

  aco_wdog #(.WDOG_BW(WDOG_BW)) u_wdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (active),
    .clr_i     (bus.aco_valid_i),
    .lim_i     (bus.wdog_lim_i),
    .expired_o (wdog_exp)
  );

  // Sequencer, window/vector counters and sticky error flags
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    num_d   = num_q;
    win_d   = win_q;
    warm_d  = warm_q;
    vec_d   = vec_q;
    err_d   = err_q;
    done_d  = 1'b0;
    data_d  = bus.mic_data_i;
    valid_d = bus.mic_valid_i & active;

    // Vector position inside the current window; resyncs on every last
    if (active) begin
      if (bus.aco_last_i) begin
        if (vec_q != VEC_LAST) err_d[ERR_ALIGN] = 1'b1;
        vec_d = '0;
      end else if (bus.aco_valid_i) begin
        if (vec_q == VEC_LAST) begin
          err_d[ERR_ALIGN] = 1'b1;
          vec_d = '0;
        end else begin
          vec_d = vec_q + VEC_BW'(1);
        end
      end
    end else begin
      vec_d = '0;
    end

    if (bus.cfg_wr_i && (state_q != ST_IDLE)) err_d[ERR_CFG] = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_wr_i) begin
          shift_d = bus.cfg_shift_i;
          state_d = ST_CFG;
        end else if (bus.start_i) begin
          num_d   = bus.num_win_i;
          err_d   = '0;
          win_d   = '0;
          warm_d  = '0;
          state_d = (DISCARD_WIN == 0) ? ST_RUN : ST_WARM;
        end
      end
      ST_CFG: state_d = ST_IDLE;
      ST_WARM: begin
        if (bus.stop_i) begin
          state_d = ST_IDLE;
        end else if (bus.aco_last_i) begin
          warm_d = warm_inc;
          if (warm_inc == CNT_BW'(DISCARD_WIN)) state_d = ST_RUN;
        end
      end
      ST_RUN, ST_STOP: begin
        if (bus.aco_last_i) win_d = win_inc;
        if (bus.aco_last_i && ((state_q == ST_STOP) || ((|num_q) && (win_inc == num_q)))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (bus.stop_i && (state_q == ST_RUN)) begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wdog_exp) begin
      err_d[ERR_WDOG] = 1'b1;
      state_d         = ST_IDLE;
      done_d          = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      num_q   <= '0;
      win_q   <= '0;
      warm_q  <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      num_q   <= num_d;
      win_q   <= win_d;
      warm_q  <= warm_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      done_q  <= done_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.aco_en_o    = (state_q != ST_IDLE);
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.aco_wr_en_o = (state_q == ST_CFG);
  assign bus.aco_shift_o = shift_q;
  assign bus.aco_data_o  = data_q;
  assign bus.aco_valid_o = valid_q;
  assign bus.out_valid_o = bus.aco_valid_i & deliver;
  assign bus.out_last_o  = bus.aco_last_i & deliver;
  assign bus.win_cnt_o   = win_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_aco_ctrl.sv
// tb/tb_aco_ctrl.sv - self-checking bench for aco_ctrl
module tb_aco_ctrl;

  localparam int WL     = 50;
  localparam int P_IDLE = 0;
  localparam int P_CFG  = 1;
  localparam int P_WARM = 2;
  localparam int P_RUN  = 3;
  localparam int P_STOP = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  aco_ctrl_if bus ();
  aco_ctrl u_dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  int ov_seen  = 0;

  // reference model of the sequencer, updated once per clock
  int         m_phase, m_num, m_win, m_vec, m_warm, m_idle;
  logic [7:0] m_shift, m_ad;
  logic [2:0] m_err;
  bit         m_done, m_av;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_num = 0; m_win = 0; m_vec = 0; m_warm = 0; m_idle = 0;
    m_shift = '0; m_ad = '0; m_err = '0; m_done = 0; m_av = 0;
  endtask

  task automatic model_step();
    m_av   = bus.mic_valid_i && (m_phase >= P_WARM);
    m_ad   = bus.mic_data_i;
    m_done = 0;
    if (m_phase == P_IDLE) begin
      if (bus.cfg_wr_i) begin
        m_shift = bus.cfg_shift_i;
        m_phase = P_CFG;
      end else if (bus.start_i) begin
        m_num = int'(bus.num_win_i); m_err = '0; m_win = 0; m_warm = 1;
        m_vec = 0; m_idle = 0; m_phase = P_WARM;
      end
    end else if (m_phase == P_CFG) begin
      if (bus.cfg_wr_i) m_err[0] = 1'b1;
      m_phase = P_IDLE;
    end else begin
      if (bus.cfg_wr_i) m_err[0] = 1'b1;
      if (bus.aco_last_i) begin
        if (m_vec != WL - 1) m_err[1] = 1'b1;
        m_vec = 0;
      end else if (bus.aco_valid_i) begin
        if (m_vec == WL - 1) begin m_err[1] = 1'b1; m_vec = 0; end
        else m_vec++;
      end
      if (bus.aco_valid_i) m_idle = 0; else m_idle++;
      if (bus.wdog_lim_i != 0 && m_idle >= int'(bus.wdog_lim_i)) begin
        m_err[2] = 1'b1;
        m_phase  = P_IDLE;
      end else if (m_phase == P_WARM) begin
        if (bus.stop_i) m_phase = P_IDLE;
        else if (bus.aco_last_i) begin
          m_warm--;
          if (m_warm == 0) m_phase = P_RUN;
        end
      end else begin
        if (bus.aco_last_i) begin
          if (m_win < 65535) m_win++;
          if (m_phase == P_STOP || (m_num != 0 && m_win == m_num)) begin
            m_phase = P_IDLE;
            m_done  = 1;
          end
        end
        if (m_phase == P_RUN && bus.stop_i) m_phase = P_STOP;
      end
    end
  endtask

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) model_reset();
    else model_step();
  end

  // per-cycle comparison of every output against the model
  always @(negedge clk_i) begin
    bit dl;
    dl = (m_phase == P_RUN) || (m_phase == P_STOP);
    chk("aco_en",    32'(bus.aco_en_o),    32'(m_phase != P_IDLE));
    chk("busy",      32'(bus.busy_o),      32'(m_phase != P_IDLE));
    chk("aco_wr_en", 32'(bus.aco_wr_en_o), 32'(m_phase == P_CFG));
    chk("aco_shift", 32'(bus.aco_shift_o), 32'(m_shift));
    chk("aco_data",  32'(bus.aco_data_o),  32'(m_ad));
    chk("aco_valid", 32'(bus.aco_valid_o), 32'(m_av));
    chk("out_valid", 32'(bus.out_valid_o), 32'(bus.aco_valid_i && dl));
    chk("out_last",  32'(bus.out_last_o),  32'(bus.aco_last_i && dl));
    chk("win_cnt",   32'(bus.win_cnt_o),   32'(m_win));
    chk("done",      32'(bus.done_o),      32'(m_done));
    chk("err",       32'(bus.err_o),       32'(m_err));
    if (bus.out_valid_o === 1'b1) ov_seen++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_vec(input bit last);
    bus.aco_valid_i = 1'b1;
    bus.aco_last_i  = last;
    bus.mic_valid_i = 1'($urandom_range(0, 1));
    bus.mic_data_i  = 8'($urandom);
    tick();
    bus.aco_valid_i = 1'b0;
    bus.aco_last_i  = 1'b0;
    bus.mic_valid_i = 1'b0;
  endtask

  task automatic send_win(input int n, input int last_at);
    for (int i = 0; i < n; i++) send_vec(i == last_at);
  endtask

  task automatic pulse_start(input int num);
    bus.num_win_i = 16'(num);
    bus.start_i   = 1'b1;
    tick();
    bus.start_i   = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop_i = 1'b1;
    tick();
    bus.stop_i = 1'b0;
  endtask

  task automatic pulse_cfg(input int shift);
    bus.cfg_shift_i = 8'(shift);
    bus.cfg_wr_i    = 1'b1;
    tick();
    bus.cfg_wr_i    = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    bus.cfg_shift_i = '0; bus.cfg_wr_i = 1'b0; bus.start_i = 1'b0; bus.stop_i = 1'b0;
    bus.num_win_i = '0; bus.wdog_lim_i = '0; bus.mic_data_i = '0; bus.mic_valid_i = 1'b0;
    bus.aco_valid_i = 1'b0; bus.aco_last_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_shift", 32'(bus.aco_shift_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);

    // program shift = 5
    pulse_cfg(5);
    bus.cfg_shift_i = 8'd9;
    chk("cfg_wr_en", 32'(bus.aco_wr_en_o), 32'd1);
    chk("cfg_en", 32'(bus.aco_en_o), 32'd1);
    chk("cfg_shift", 32'(bus.aco_shift_o), 32'd5);
    tick();
    chk("cfg_wr_en_off", 32'(bus.aco_wr_en_o), 32'd0);
    chk("cfg_busy_off", 32'(bus.busy_o), 32'd0);
    chk("cfg_shift_held", 32'(bus.aco_shift_o), 32'd5);

    // two delivered windows after one discarded warm-up window
    pulse_start(2);
    ov_seen = 0;
    repeat (3) send_win(WL, WL - 1);
    chk("run2_done", 32'(bus.done_o), 32'd1);
    chk("run2_en", 32'(bus.aco_en_o), 32'd0);
    chk("run2_win", 32'(bus.win_cnt_o), 32'd2);
    chk("run2_ov", 32'(ov_seen), 32'd100);
    tick();
    chk("run2_done_pulse", 32'(bus.done_o), 32'd0);

    // unbounded run stopped at vector 20 of a window
    pulse_start(0);
    send_win(WL, WL - 1);
    send_win(WL, WL - 1);
    send_win(20, -1);
    ov_seen = 0;
    pulse_stop();
    send_win(30, 29);
    chk("stop_ov", 32'(ov_seen), 32'd30);
    chk("stop_done", 32'(bus.done_o), 32'd1);
    chk("stop_busy", 32'(bus.busy_o), 32'd0);
    chk("stop_win", 32'(bus.win_cnt_o), 32'd2);
    chk("stop_err", 32'(bus.err_o), 32'd0);

    // early last, then a cfg write while running
    pulse_start(0);
    send_win(WL, WL - 1);
    send_win(40, 39);
    chk("align_err", 32'(bus.err_o), 32'b010);
    send_win(WL, WL - 1);
    chk("align_win", 32'(bus.win_cnt_o), 32'd2);
    chk("align_err_hold", 32'(bus.err_o), 32'b010);
    pulse_cfg(7);
    chk("cfg_in_run_err", 32'(bus.err_o), 32'b011);
    chk("cfg_in_run_shift", 32'(bus.aco_shift_o), 32'd5);
    pulse_stop();
    send_win(WL, WL - 1);
    chk("align_done", 32'(bus.done_o), 32'd1);
    chk("align_win3", 32'(bus.win_cnt_o), 32'd3);

    // watchdog expiry after 100 idle cycles in RUN
    bus.wdog_lim_i = 20'd100;
    pulse_start(0);
    chk("start_clears_err", 32'(bus.err_o), 32'd0);
    send_win(WL, WL - 1);
    send_win(WL, WL - 1);
    repeat (99) tick();
    chk("wdog_pre_busy", 32'(bus.busy_o), 32'd1);
    tick();
    chk("wdog_busy", 32'(bus.busy_o), 32'd0);
    chk("wdog_err", 32'(bus.err_o), 32'b100);
    chk("wdog_no_done", 32'(bus.done_o), 32'd0);
    pulse_start(5);
    chk("wdog_clear_err", 32'(bus.err_o), 32'd0);
    chk("warm_busy", 32'(bus.busy_o), 32'd1);
    pulse_stop();
    chk("warm_stop_busy", 32'(bus.busy_o), 32'd0);
    chk("warm_stop_no_done", 32'(bus.done_o), 32'd0);
    bus.wdog_lim_i = '0;

    // asynchronous reset in the middle of a run
    pulse_start(3);
    send_win(WL, WL - 1);
    send_win(WL, WL - 1);
    bus.aco_valid_i = 1'b1;
    bus.mic_valid_i = 1'b1;
    tick();
    rst_i = 1'b1;
    #1;
    chk("rst_mid_en", 32'(bus.aco_en_o), 32'd0);
    chk("rst_mid_win", 32'(bus.win_cnt_o), 32'd0);
    chk("rst_mid_valid", 32'(bus.aco_valid_o), 32'd0);
    chk("rst_mid_shift", 32'(bus.aco_shift_o), 32'd0);
    bus.aco_valid_i = 1'b0;
    bus.mic_valid_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    pulse_start(1);
    ov_seen = 0;
    send_win(WL, WL - 1);
    send_win(WL, WL - 1);
    chk("fresh_done", 32'(bus.done_o), 32'd1);
    chk("fresh_win", 32'(bus.win_cnt_o), 32'd1);
    chk("fresh_ov", 32'(ov_seen), 32'd50);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
